// File: rtl/qtpa_pkg.sv
// Shared types and sizing for the writeback-end register file.
package qtpa_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int SB_CNT_W   = 2;

  typedef logic [3:0] reg_addr_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters with saturation/underflow error
// tracking and busy lookup for the two decode read addresses.
// Optional feature: QTPA_WB_BYPASS_EN masks busy when the retiring write
// is the last pending one and its data is being forwarded this cycle.
module wb_scoreboard
  import qtpa_pkg::*;
#(
  parameter int NUM_REGS = qtpa_pkg::NUM_REGS,
  parameter int SB_CNT_W = qtpa_pkg::SB_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      iss_valid,
  input  reg_addr_t iss_rd,
  input  logic      wb_we,
  input  reg_addr_t wb_rd_addr,
  input  logic      sb_clear,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      sb_err
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);

  logic [SB_CNT_W-1:0] cnt_q [NUM_REGS];
  logic [SB_CNT_W-1:0] cnt_d [NUM_REGS];
  logic                sb_err_q;
  logic                sb_err_d;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Decode which register is being issued to and which is retiring; R0 never counts.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = iss_valid && (iss_rd == reg_addr_t'(r));
      dec_vec[r] = wb_we && (wb_rd_addr == reg_addr_t'(r));
    end
  end

  // Next counter values: clear wins, issue+retire cancel, otherwise saturate or flag errors.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (sb_clear) begin
        cnt_d[r] = CNT_ZERO;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == CNT_ZERO) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  // Busy lookup for both read addresses, optionally masked by a forwarding last retire.
  always_comb begin
    rs1_busy = (cnt_q[rs1_addr] != CNT_ZERO);
    rs2_busy = (cnt_q[rs2_addr] != CNT_ZERO);
`ifdef QTPA_WB_BYPASS_EN
    if (wb_we && (wb_rd_addr == rs1_addr) && (cnt_q[rs1_addr] == CNT_ONE)) begin
      rs1_busy = 1'b0;
    end
    if (wb_we && (wb_rd_addr == rs2_addr) && (cnt_q[rs2_addr] == CNT_ONE)) begin
      rs2_busy = 1'b0;
    end
`endif
  end

  assign sb_err = sb_err_q;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file, flags register and RAW scoreboard at the
// end of the EX/WB pipeline register.
// Optional feature: QTPA_WB_BYPASS_EN forwards the writeback result to a
// matching read port in the same cycle.
module wb_regfile
  import qtpa_pkg::*;
#(
  parameter int NUM_REGS = qtpa_pkg::NUM_REGS,
  parameter int SB_CNT_W = qtpa_pkg::SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  reg_addr_t             wb_rd_addr,
  input  logic                  wb_we,
  input  logic                  wb_flags_we,
  input  logic                  wb_flag_zero,
  input  logic                  wb_flag_carry,
  input  logic                  wb_flag_ovf,
  input  logic                  iss_valid,
  input  reg_addr_t             iss_rd,
  input  logic                  sb_clear,
  input  reg_addr_t             rs1_addr,
  input  reg_addr_t             rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  output logic                  sb_err
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  flags_t                flags_q;
  flags_t                flags_d;

  // Commit the writeback result; R0 is hardwired to zero so writes to it are dropped.
  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_rd_addr != '0)) begin
      regs_d[wb_rd_addr] = wb_alu_result;
    end
  end

  // All three flags load together or hold.
  always_comb begin
    flags_d = flags_q;
    if (wb_flags_we) begin
      flags_d = '{zero: wb_flag_zero, carry: wb_flag_carry, ovf: wb_flag_ovf};
    end
  end

  // Register array and flags storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

  // Combinational read ports, with optional same-cycle forwarding of the writeback result.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef QTPA_WB_BYPASS_EN
    if (wb_we && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr)) begin
      rs1_data = wb_alu_result;
    end
    if (wb_we && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr)) begin
      rs2_data = wb_alu_result;
    end
`endif
  end

  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_ovf   = flags_q.ovf;

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SB_CNT_W (SB_CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .wb_we      (wb_we),
    .wb_rd_addr (wb_rd_addr),
    .sb_clear   (sb_clear),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run against a behavioural model of the register file, flags and scoreboard.
module tb_wb_regfile;
  import qtpa_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [DATA_WIDTH-1:0] wb_alu_result;
  reg_addr_t             wb_rd_addr;
  logic                  wb_we;
  logic                  wb_flags_we;
  logic                  wb_flag_zero;
  logic                  wb_flag_carry;
  logic                  wb_flag_ovf;
  logic                  iss_valid;
  reg_addr_t             iss_rd;
  logic                  sb_clear;
  reg_addr_t             rs1_addr;
  reg_addr_t             rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  flag_zero;
  logic                  flag_carry;
  logic                  flag_ovf;
  logic                  sb_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] m_regs [16];
  int                    m_cnt  [16];
  logic                  m_err;
  logic [2:0]            m_flags;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .wb_alu_result (wb_alu_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_we         (wb_we),
    .wb_flags_we   (wb_flags_we),
    .wb_flag_zero  (wb_flag_zero),
    .wb_flag_carry (wb_flag_carry),
    .wb_flag_ovf   (wb_flag_ovf),
    .iss_valid     (iss_valid),
    .iss_rd        (iss_rd),
    .sb_clear      (sb_clear),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .flag_ovf      (flag_ovf),
    .sb_err        (sb_err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
    m_err   = 1'b0;
    m_flags = 3'b000;
  endfunction

  // Architectural effect of one clock edge given the currently driven inputs.
  function automatic void model_update();
    int wr;
    int ir;
    wr = int'(wb_rd_addr);
    ir = int'(iss_rd);
    if (wb_we && wr != 0) m_regs[wr] = wb_alu_result;
    if (wb_flags_we) m_flags = {wb_flag_zero, wb_flag_carry, wb_flag_ovf};
    if (sb_clear) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      int delta [16];
      for (int i = 0; i < 16; i++) delta[i] = 0;
      if (iss_valid && ir != 0) delta[ir] += 1;
      if (wb_we && wr != 0) delta[wr] -= 1;
      for (int i = 1; i < 16; i++) begin
        if (m_cnt[i] + delta[i] > 3) m_err = 1'b1;
        else if (m_cnt[i] + delta[i] < 0) m_err = 1'b1;
        else m_cnt[i] = m_cnt[i] + delta[i];
      end
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] exp_data(input reg_addr_t a);
    if (a == 4'd0) return '0;
`ifdef QTPA_WB_BYPASS_EN
    if (wb_we && wb_rd_addr == a) return wb_alu_result;
`endif
    return m_regs[int'(a)];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
`ifdef QTPA_WB_BYPASS_EN
    if (wb_we && wb_rd_addr == a && m_cnt[int'(a)] == 1) return 1'b0;
`endif
    return m_cnt[int'(a)] != 0;
  endfunction

  task automatic idle_inputs();
    wb_alu_result = '0;
    wb_rd_addr    = '0;
    wb_we         = 1'b0;
    wb_flags_we   = 1'b0;
    wb_flag_zero  = 1'b0;
    wb_flag_carry = 1'b0;
    wb_flag_ovf   = 1'b0;
    iss_valid     = 1'b0;
    iss_rd        = '0;
    sb_clear      = 1'b0;
  endtask

  // One clock edge: the model follows the DUT, then we park on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rs1_addr = '0;
    rs2_addr = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 16; a++) begin
      rs1_addr = reg_addr_t'(a);
      rs2_addr = reg_addr_t'(15 - a);
      #1;
      checks++;
      if (rs1_data !== '0 || rs2_data !== '0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_read r%0d: data %h/%h busy %b/%b, need 0/0 busy 0/0",
                 a, rs1_data, rs2_data, rs1_busy, rs2_busy);
      end
    end
    checks++;
    if ({flag_zero, flag_carry, flag_ovf, sb_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: zcv+err %b, need 0000",
               {flag_zero, flag_carry, flag_ovf, sb_err});
    end
  endtask

  task automatic test_write_read();
    do_reset();
    rs1_addr      = 4'd3;
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd3;
    wb_alu_result = 32'h0000_00A5;
    #1;
    checks++;
`ifdef QTPA_WB_BYPASS_EN
    if (rs1_data !== 32'h0000_00A5) begin
`else
    if (rs1_data !== 32'h0) begin
`endif
      errors++;
      $display("[TB] FAIL write_same_cycle: got %h, need %h", rs1_data, exp_data(4'd3));
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'h0000_00A5) begin
      errors++;
      $display("[TB] FAIL write_r3: got %h, need 000000a5", rs1_data);
    end
    // The R3 retire had no matching issue, so the scoreboard underflowed.
    checks++;
    if (sb_err !== m_err || sb_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underflow_err: got %b, need 1", sb_err);
    end
    rs1_addr      = 4'd0;
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd0;
    wb_alu_result = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs1_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_r0: data %h busy %b, need 0 busy 0", rs1_data, rs1_busy);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    rs1_addr = 4'd5;
    for (int k = 0; k < 4; k++) begin
      iss_valid = 1'b1;
      iss_rd    = 4'd5;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rs1_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL issue_busy_%0d: got %b, need 1", k, rs1_busy);
      end
      checks++;
      if (sb_err !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL overflow_err_%0d: got %b, need %b", k, sb_err, (k == 3));
      end
    end
    for (int k = 0; k < 3; k++) begin
      wb_we         = 1'b1;
      wb_rd_addr    = 4'd5;
      wb_alu_result = 32'h5500 + k;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (rs1_busy !== (k != 2)) begin
        errors++;
        $display("[TB] FAIL retire_busy_%0d: got %b, need %b", k, rs1_busy, (k != 2));
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    rs1_addr  = 4'd7;
    iss_valid = 1'b1;
    iss_rd    = 4'd7;
    tick();
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd7;
    wb_alu_result = 32'h7777;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || sb_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL iss_ret_same: busy %b err %b, need busy 1 err 0", rs1_busy, sb_err);
    end
    // A lone retire now must drain to zero without error if the count stayed at 1.
    wb_we      = 1'b1;
    wb_rd_addr = 4'd7;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || sb_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL iss_ret_drain: busy %b err %b, need busy 0 err 0", rs1_busy, sb_err);
    end
    iss_valid = 1'b1;
    iss_rd    = 4'd7;
    tick();
    sb_clear  = 1'b1;
    iss_valid = 1'b1;
    iss_rd    = 4'd7;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || sb_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_priority: busy %b err %b, need busy 0 err 0", rs1_busy, sb_err);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    rs2_addr      = 4'd2;
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd2;
    wb_alu_result = 32'hBEEF;
    iss_valid     = 1'b1;
    iss_rd        = 4'd2;
    tick();
    idle_inputs();
    iss_valid = 1'b1;
    iss_rd    = 4'd2;
    tick();
    idle_inputs();
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd2;
    wb_alu_result = 32'h1234;
    #1;
    checks++;
`ifdef QTPA_WB_BYPASS_EN
    if (rs2_data !== 32'h1234 || rs2_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass: data %h busy %b, need 00001234 busy 0", rs2_data, rs2_busy);
    end
`else
    if (rs2_data !== 32'hBEEF || rs2_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_bypass: data %h busy %b, need 0000beef busy 1", rs2_data, rs2_busy);
    end
`endif
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rs2_data !== 32'h1234 || rs2_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_retire: data %h busy %b, need 00001234 busy 0", rs2_data, rs2_busy);
    end
  endtask

  task automatic test_flags();
    do_reset();
    wb_flags_we   = 1'b1;
    wb_flag_zero  = 1'b1;
    wb_flag_carry = 1'b0;
    wb_flag_ovf   = 1'b1;
    #1;
    checks++;
    if ({flag_zero, flag_carry, flag_ovf} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL flags_early: got %b, need 000", {flag_zero, flag_carry, flag_ovf});
    end
    tick();
    wb_flags_we   = 1'b0;
    wb_flag_zero  = 1'b0;
    wb_flag_carry = 1'b0;
    wb_flag_ovf   = 1'b0;
    #1;
    checks++;
    if ({flag_zero, flag_carry, flag_ovf} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL flags_load: got %b, need 101", {flag_zero, flag_carry, flag_ovf});
    end
    tick();
    checks++;
    if ({flag_zero, flag_carry, flag_ovf} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL flags_hold: got %b, need 101", {flag_zero, flag_carry, flag_ovf});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd9;
    wb_alu_result = 32'hCAFE_F00D;
    iss_valid     = 1'b1;
    iss_rd        = 4'd4;
    wb_flags_we   = 1'b1;
    wb_flag_zero  = 1'b1;
    wb_flag_carry = 1'b1;
    wb_flag_ovf   = 1'b1;
    tick();
    idle_inputs();
    rs1_addr      = 4'd9;
    rs2_addr      = 4'd4;
    wb_we         = 1'b1;
    wb_rd_addr    = 4'd11;
    wb_alu_result = 32'h1111_2222;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_busy !== 1'b0 || sb_err !== 1'b0 ||
        {flag_zero, flag_carry, flag_ovf} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL async_reset: data %h busy %b err %b flags %b, need all 0",
               rs1_data, rs2_busy, sb_err, {flag_zero, flag_carry, flag_ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    rs1_addr = 4'd11;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lost_write: got %h, need 0", rs1_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      wb_alu_result = $urandom;
      wb_rd_addr    = reg_addr_t'($urandom_range(0, 15));
      wb_we         = ($urandom_range(0, 2) == 0);
      wb_flags_we   = $urandom_range(0, 1) == 1;
      wb_flag_zero  = $urandom_range(0, 1) == 1;
      wb_flag_carry = $urandom_range(0, 1) == 1;
      wb_flag_ovf   = $urandom_range(0, 1) == 1;
      iss_valid     = ($urandom_range(0, 1) == 1);
      iss_rd        = reg_addr_t'($urandom_range(0, 15));
      sb_clear      = ($urandom_range(0, 40) == 0);
      rs1_addr      = ($urandom_range(0, 3) == 0) ? wb_rd_addr : reg_addr_t'($urandom_range(0, 15));
      rs2_addr      = reg_addr_t'($urandom_range(0, 15));
      if (n == 250) begin
        do_reset();
      end
      #1;
      checks++;
      if (rs1_data !== exp_data(rs1_addr) || rs2_data !== exp_data(rs2_addr)) begin
        errors++;
        $display("[TB] FAIL rand_data cyc %0d: got %h/%h, need %h/%h", n,
                 rs1_data, rs2_data, exp_data(rs1_addr), exp_data(rs2_addr));
      end
      checks++;
      if (rs1_busy !== exp_busy(rs1_addr) || rs2_busy !== exp_busy(rs2_addr)) begin
        errors++;
        $display("[TB] FAIL rand_busy cyc %0d: got %b/%b, need %b/%b", n,
                 rs1_busy, rs2_busy, exp_busy(rs1_addr), exp_busy(rs2_addr));
      end
      checks++;
      if ({flag_zero, flag_carry, flag_ovf} !== m_flags || sb_err !== m_err) begin
        errors++;
        $display("[TB] FAIL rand_state cyc %0d: flags %b err %b, need %b err %b", n,
                 {flag_zero, flag_carry, flag_ovf}, sb_err, m_flags, m_err);
      end
      tick();
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    rst = 1'b1;
    idle_inputs();
    rs1_addr = '0;
    rs2_addr = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_saturate();
    test_same_cycle();
    test_bypass();
    test_flags();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
